// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle controller and its datapath.
interface mc_control_fsm_if;
    logic [6:0] opcode;
    logic       alu_bcond;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] rd_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       halted;
    logic [3:0] state;

    // Controller side: consumes instruction/status, drives control strobes.
    modport master (
        input  opcode, alu_bcond, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_write, rd_src, alu_src_a, alu_src_b, alu_op, pc_source,
               halted, state
    );

    // Datapath side: the mirror image of the controller.
    modport slave (
        output opcode, alu_bcond, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_write, rd_src, alu_src_a, alu_src_b, alu_op, pc_source,
               halted, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V style control FSM. Control strobes are decoded from the
// current state (plus mem_ready/reset where noted) so the datapath sees them
// in the same cycle the state is entered.
module mc_control_fsm (
    input  logic             clk,
    input  logic             reset,
    mc_control_fsm_if.master bus
);
    localparam int unsigned STATE_W = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    typedef enum logic [STATE_W-1:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EX_R     = 4'd2,
        S_EX_I     = 4'd3,
        S_WB_ALU   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_EX_B     = 4'd9,
        S_PC_INC   = 4'd10,
        S_JAL      = 4'd11,
        S_EX_JALR  = 4'd12,
        S_JALR_WB  = 4'd13,
        S_HALT     = 4'd14,
        S_BAD      = 4'd15
    } state_t;

    state_t state_q;
    state_t state_next;
    logic   halted_q;

    logic       pc_write_c;
    logic       pc_write_cond_c;
    logic       i_or_d_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic [1:0] rd_src_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic       pc_source_c;

    // State register and sticky halt flag; synchronous reset returns to fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IF;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_next;
            halted_q <= (state_next == S_HALT);
        end
    end

    // Next-state selection and per-state control decode.
    always_comb begin
        state_next      = state_q;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        i_or_d_c        = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        reg_write_c     = 1'b0;
        rd_src_c        = 2'b00;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'b00;
        alu_op_c        = 2'b00;
        pc_source_c     = 1'b0;

        case (state_q)
            S_IF: begin
                mem_read_c = 1'b1;
                ir_write_c = bus.mem_ready;
                if (bus.mem_ready) state_next = S_ID;
            end
            S_ID: begin
                alu_src_b_c = 2'b10;
                case (bus.opcode)
                    OP_R:              state_next = S_EX_R;
                    OP_I:              state_next = S_EX_I;
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
                    OP_BR:             state_next = S_EX_B;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_EX_JALR;
                    OP_SYS:            state_next = S_HALT;
                    default:           state_next = S_PC_INC;
                endcase
            end
            S_EX_R: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
                state_next  = S_WB_ALU;
            end
            S_EX_I: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_op_c    = 2'b10;
                state_next  = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write_c = 1'b1;
                alu_src_b_c = 2'b01;
                pc_write_c  = 1'b1;
                state_next  = S_IF;
            end
            S_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_next  = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                i_or_d_c   = 1'b1;
                mem_read_c = 1'b1;
                if (bus.mem_ready) state_next = S_WB_MEM;
            end
            S_WB_MEM: begin
                reg_write_c = 1'b1;
                rd_src_c    = 2'b01;
                alu_src_b_c = 2'b01;
                pc_write_c  = 1'b1;
                state_next  = S_IF;
            end
            S_MEM_WR: begin
                // PC only advances in the cycle the store actually completes.
                i_or_d_c    = 1'b1;
                mem_write_c = 1'b1;
                alu_src_b_c = 2'b01;
                pc_write_c  = bus.mem_ready;
                if (bus.mem_ready) state_next = S_IF;
            end
            S_EX_B: begin
                alu_src_a_c     = 1'b1;
                alu_op_c        = 2'b01;
                pc_source_c     = 1'b1;
                pc_write_cond_c = 1'b1;
                state_next      = bus.alu_bcond ? S_IF : S_PC_INC;
            end
            S_PC_INC: begin
                alu_src_b_c = 2'b01;
                pc_write_c  = 1'b1;
                state_next  = S_IF;
            end
            S_JAL, S_JALR_WB: begin
                // rd <- PC+4 from the ALU while PC loads the target from ALUOut.
                alu_src_b_c = 2'b01;
                reg_write_c = 1'b1;
                rd_src_c    = 2'b10;
                pc_write_c  = 1'b1;
                pc_source_c = 1'b1;
                state_next  = S_IF;
            end
            S_EX_JALR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_next  = S_JALR_WB;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IF;
            end
        endcase

        // Reset suppresses every side-effecting strobe immediately.
        if (reset) begin
            pc_write_c      = 1'b0;
            pc_write_cond_c = 1'b0;
            ir_write_c      = 1'b0;
            reg_write_c     = 1'b0;
            mem_read_c      = 1'b0;
            mem_write_c     = 1'b0;
        end
    end

    assign bus.pc_write      = pc_write_c;
    assign bus.pc_write_cond = pc_write_cond_c;
    assign bus.i_or_d        = i_or_d_c;
    assign bus.mem_read      = mem_read_c;
    assign bus.mem_write     = mem_write_c;
    assign bus.ir_write      = ir_write_c;
    assign bus.reg_write     = reg_write_c;
    assign bus.rd_src        = rd_src_c;
    assign bus.alu_src_a     = alu_src_a_c;
    assign bus.alu_src_b     = alu_src_b_c;
    assign bus.alu_op        = alu_op_c;
    assign bus.pc_source     = pc_source_c;
    assign bus.halted        = halted_q;
    assign bus.state         = STATE_W'(state_q);
endmodule
